// File: rtl/mips32_pkg.sv
// Shared MIPS32 constants: datapath widths, architectural register indices
// and the reset value loaded into the stack pointer.
package mips32_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: 32:1 select, $zero override,
// same-cycle writeback bypass and force-to-zero while reset is held.
module rf_read_port
  import mips32_pkg::*;
#(
  parameter int D_W = DATA_W,
  parameter int A_W = ADDR_W
) (
  input  logic                          rst_n,
  input  logic [(2**A_W)-1:0][D_W-1:0]  regs,
  input  logic [A_W-1:0]                ra,
  input  logic [A_W-1:0]                wa,
  input  logic [D_W-1:0]                wd,
  input  logic                          we,
  output logic [D_W-1:0]                rd
);

  // The ra != 0 test comes first, so the bypass can never leak a $zero write.
  always_comb begin
    rd = '0;
    if (!rst_n) begin
      rd = '0;
    end else if (ra == A_W'(REG_ZERO)) begin
      rd = '0;
    end else if (we && (wa == ra)) begin
      rd = wd;
    end else begin
      rd = regs[ra];
    end
  end

endmodule

// File: rtl/reg_file32.sv
// MIPS32 general-purpose register file: 32 x 32-bit storage, one synchronous
// write port and two bypassed combinational read ports.
module reg_file32
  import mips32_pkg::*;
#(
  parameter int          DATA_W  = mips32_pkg::DATA_W,
  parameter int          ADDR_W  = mips32_pkg::ADDR_W,
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // Reset takes priority over a write arriving on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
      regs[ADDR_W'(REG_SP)] <= DATA_W'(SP_INIT);
    end else if (WE && (WA != ADDR_W'(REG_ZERO))) begin
      regs[WA] <= WD;
    end
  end

  rf_read_port #(
    .D_W (DATA_W),
    .A_W (ADDR_W)
  ) u_port1 (
    .rst_n (rst_n),
    .regs  (regs),
    .ra    (RA1),
    .wa    (WA),
    .wd    (WD),
    .we    (WE),
    .rd    (RD1)
  );

  rf_read_port #(
    .D_W (DATA_W),
    .A_W (ADDR_W)
  ) u_port2 (
    .rst_n (rst_n),
    .regs  (regs),
    .ra    (RA2),
    .wa    (WA),
    .wd    (WD),
    .we    (WE),
    .rd    (RD2)
  );

endmodule

// File: tb/tb_reg_file32.sv
// Scoreboard bench for reg_file32: stimulus pushes expected read data from an
// array-based register model; a negedge monitor pops and compares.
module tb_reg_file32;

  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

  logic        clk;
  logic        rst_n;
  logic [4:0]  RA1, RA2, WA;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD1, RD2;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  reg_file32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RA1   (RA1),
    .RA2   (RA2),
    .WA    (WA),
    .WD    (WD),
    .WE    (WE),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What a decode read of register ra sees this cycle, from the architectural rules.
  function automatic logic [31:0] expectedRead(input logic [4:0] ra);
    if (!rst_n)               return 32'h0;
    if (ra == 5'd0)           return 32'h0;
    if (WE && WA == ra)       return WD;
    return model[ra];
  endfunction

  // Commits the inputs sampled at the edge just taken into the model.
  task automatic commitModel();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[29] = SP_VAL;
    end else if (WE && WA != 5'd0) begin
      model[WA] = WD;
    end
  endtask

  task automatic applyStimulus(input string name, input logic rst_v, input logic we_v,
                               input logic [4:0] wa_v, input logic [31:0] wd_v,
                               input logic [4:0] ra1_v, input logic [4:0] ra2_v);
    exp_t e;
    @(posedge clk);
    commitModel();
    #1;
    rst_n = rst_v;
    WE    = we_v;
    WA    = wa_v;
    WD    = wd_v;
    RA1   = ra1_v;
    RA2   = ra2_v;
    e.rd1 = expectedRead(ra1_v);
    e.rd2 = expectedRead(ra2_v);
    e.ra1 = ra1_v;
    e.ra2 = ra2_v;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic checkOutput(input string name, input string port, input logic [4:0] ra,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s %s (ra=%0d): got %h, expected %h", name, port, ra, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, "RD1", e.ra1, RD1, e.rd1);
      checkOutput(n, "RD2", e.ra2, RD2, e.rd2);
    end
  end

  initial begin
    logic        r, w;
    logic [4:0]  a, x1, x2;
    logic [31:0] d;

    rst_n = 1'b0;
    WE    = 1'b0;
    WA    = 5'd0;
    WD    = 32'h0;
    RA1   = 5'd0;
    RA2   = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    $display("[TB] reset");
    applyStimulus("reset_hold", 1'b0, 1'b1, 5'd3, 32'hAAAA_5555, 5'd29, 5'd3);
    applyStimulus("reset_hold", 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd29);
    for (int i = 0; i < 32; i++)
      applyStimulus("reset_values", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    $display("[TB] basic write/read");
    applyStimulus("basic_write", 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
    applyStimulus("basic_read", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);

    $display("[TB] zero register");
    applyStimulus("zero_write", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    applyStimulus("zero_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    applyStimulus("zero_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    $display("[TB] bypass");
    applyStimulus("bypass_pre", 1'b1, 1'b1, 5'd8, 32'h1111_1111, 5'd0, 5'd0);
    applyStimulus("bypass_old", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    applyStimulus("bypass_same", 1'b1, 1'b1, 5'd8, 32'h2222_2222, 5'd8, 5'd8);
    applyStimulus("bypass_store", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd5);
    applyStimulus("write_other", 1'b1, 1'b1, 5'd7, 32'h7777_0000, 5'd8, 5'd7);

    $display("[TB] reset mid-write");
    applyStimulus("reset_write", 1'b1, 1'b1, 5'd9, 32'hCAFE_0009, 5'd0, 5'd0);
    applyStimulus("reset_write", 1'b0, 1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd29);
    applyStimulus("reset_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd29);
    applyStimulus("reset_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd5);

    $display("[TB] random");
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(99) >= 5);
      w  = $urandom_range(1);
      a  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      d  = $urandom;
      x1 = ($urandom_range(3) == 0) ? a : 5'($urandom_range(31));
      x2 = ($urandom_range(3) == 0) ? a : (($urandom_range(4) == 0) ? x1 : 5'($urandom_range(31)));
      applyStimulus("random", r, w, a, d, x1, x2);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
